spi_master: RTL and testbench
=============================

// Module: spi_master
// PURPOSE
//  SPI mode-0 master (CPOL=0, CPHA=0), MSB first, one chip select.
//  Drives frames into the board's SPI_Slave for loopback and bring-up, using the same
//  parallel handshake: data_in/data_in_valid in, data_out/data_out_valid out, busy.
//  Each accepted word becomes one full-duplex frame; the word received on miso is returned.
// PARAMETERS
//  DATA_WIDTH  8  bits per frame
//  CLK_DIV     4  clk cycles per sck half-period (>=2); sck = clk/(2*CLK_DIV)
// PORTS
//  clk             in   1           system clock; all logic on posedge
//  rst             in   1           synchronous, active-high reset
//  sck             out  1           SPI clock, idles low
//  cs              out  1           chip select, active low, idles high
//  mosi            out  1           serial data out, MSB first
//  miso            in   1           serial data in; sampled on sck rising edge
//  data_in         in   DATA_WIDTH  word to transmit
//  data_in_valid   in   1           1-cycle request; captured when busy=0
//  data_out        out  DATA_WIDTH  last received word
//  data_out_valid  out  1           1-cycle pulse, data_out updated same cycle
//  busy            out  1           high from the cycle after acceptance until back in IDLE
// BEHAVIOUR
//  Reset values: sck=0, cs=1, mosi=0, busy=0, data_out=0, data_out_valid=0, state=IDLE.
//  Reset mid-frame aborts immediately (next edge). No partial data_out_valid. cs rises without sck glitch.
//  Divider counter counts 0..CLK_DIV-1. It runs only outside IDLE. Each phase below lasts CLK_DIV cycles.
//  IDLE:  on data_in_valid, load shift reg with data_in, then enter SETUP. busy=1 from next cycle.
//  SETUP: cs=0, mosi=MSB, sck=0. Lasts CLK_DIV cycles, then SHIFT.
//  SHIFT: sck low for CLK_DIV cycles, then high for CLK_DIV cycles.
//    Rising edge: sample miso into rx reg LSB, shifting left.
//    Falling edge: shift tx reg and present next bit on mosi.
//    After DATA_WIDTH rising edges and the final falling edge, go to HOLD. sck ends low.
//  HOLD:  cs still 0 for CLK_DIV cycles. On exit, cs=1 and data_out<=rx reg.
//    data_out_valid=1 for exactly that cycle. Then GAP.
//  GAP:   cs=1 for CLK_DIV cycles (min deselect time). Then IDLE, busy=0.
//  Frame: cs low for (2*DATA_WIDTH+2)*CLK_DIV cycles. Exactly DATA_WIDTH sck rising edges.
//  data_in_valid while busy=1 is ignored (see BURST option). data_in needs to be valid only in its valid cycle.
//  A valid in the same cycle busy falls is accepted (busy is registered; acceptance uses state==IDLE).
//  mosi held stable for the whole sck high phase. It changes only on sck falling edges or in SETUP.
//  Bit counter width = clog2(DATA_WIDTH+1); no wrap beyond DATA_WIDTH.
// CONFIGURATION
//  SPI_MASTER_BURST_EN defined:
//    Adds a 1-entry pending register.
//    A data_in_valid during SETUP/SHIFT/HOLD with the pending register empty is stored in it.
//    Further valids while it is full are dropped.
//    At HOLD exit with pending full, cs stays 0 and data_out_valid still pulses.
//    The pending word loads directly into SHIFT (no SETUP/GAP); pending clears.
//  SPI_MASTER_BURST_EN undefined: no pending register; every frame is IDLE->SETUP->SHIFT->HOLD->GAP.
// TESTING (CLK_DIV=2, DATA_WIDTH=8; bench slave model drives miso on sck falling edges)
//  1 Reset:
//    Assert rst for 3 cycles mid-frame.
//    Expect cs=1, sck=0, busy=0, data_out=0 next cycle, and no data_out_valid.
//  2 Single frame:
//    Send data_in=0xA5; slave returns 0x3C.
//    Expect mosi bits 1,0,1,0,0,1,0,1 at rising edges, 8 sck pulses, cs low 36 cycles.
//    Expect data_out=0x3C with one data_out_valid pulse.
//  3 Busy ignore:
//    Pulse valid with 0xFF during SHIFT (macro off).
//    Expect no second frame; slave sees only 0xA5.
//  4 Back-to-back:
//    Re-assert valid in the cycle after busy falls; send 0x00 then 0xFF; slave echoes.
//    Expect two frames, each separated by >=2 cycles cs high, with data_out 0x00 then 0xFF.
//  5 Burst (macro on):
//    Send 0x12, then 0x34 during SHIFT, then 0x56 (dropped).
//    Expect one cs-low window, 16 sck pulses, two data_out_valid pulses, slave receives 0x12,0x34.
//  6 Divider:
//    Set CLK_DIV=5.
//    Expect sck high and low phases of 5 clk each; data_out matches slave for 0x81.

Source files
------------

// File: rtl/spi_master.sv
// SPI mode-0 master (CPOL=0, CPHA=0), MSB first, single active-low chip select.
// One accepted word becomes one full-duplex frame; the word shifted in on miso
// is returned on data_out with a one-cycle data_out_valid pulse.
// Optional feature macro: SPI_MASTER_BURST_EN adds a one-entry pending word so
// back-to-back frames share a single cs-low window.
module spi_master #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  sck,
    output logic                  cs,
    output logic                  mosi,
    input  logic                  miso,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    output logic                  busy
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t                state, state_n;
    logic [CW-1:0]         div_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] tx_sr;
    logic [DATA_WIDTH-1:0] rx_sr;
    logic                  sck_r;

    logic                  phase_end;
    logic                  accept;
    logic                  rise;
    logic                  fall;
    logic                  hold_exit;
    logic                  chain_req;
    logic                  chain;
    logic [DATA_WIDTH-1:0] chain_word;

    assign phase_end = (div_cnt == DIV_LAST);

`ifdef SPI_MASTER_BURST_EN
    logic                  pend_full;
    logic [DATA_WIDTH-1:0] pend_word;
    logic                  pend_take;

    // A word arriving in the very cycle HOLD ends is chained directly.
    assign chain_req  = pend_full || data_in_valid;
    assign chain_word = pend_full ? pend_word : data_in;
    assign pend_take  = data_in_valid && !pend_full &&
                        (state inside {SETUP, SHIFT, HOLD});

    // Pending word: filled while a frame is in flight, emptied at HOLD exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_full <= 1'b0;
            pend_word <= '0;
        end else if (hold_exit) begin
            pend_full <= 1'b0;
        end else if (pend_take) begin
            pend_full <= 1'b1;
            pend_word <= data_in;
        end
    end
`else
    assign chain_req  = 1'b0;
    assign chain_word = '0;
`endif

    assign chain = hold_exit && chain_req;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state, phase strobes and decoded outputs.
    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        rise      = 1'b0;
        fall      = 1'b0;
        hold_exit = 1'b0;
        cs        = 1'b1;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (data_in_valid) begin
                    accept  = 1'b1;
                    state_n = SETUP;
                end
            end
            SETUP: begin
                cs = 1'b0;
                if (phase_end) state_n = SHIFT;
            end
            SHIFT: begin
                cs = 1'b0;
                if (phase_end) begin
                    if (!sck_r) begin
                        rise = 1'b1;
                    end else begin
                        fall = 1'b1;
                        if (bit_cnt == BIT_LAST) state_n = HOLD;
                    end
                end
            end
            HOLD: begin
                cs = 1'b0;
                if (phase_end) begin
                    hold_exit = 1'b1;
                    state_n   = chain_req ? SHIFT : GAP;
                end
            end
            GAP: begin
                if (phase_end) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Divider, shift registers, bit count and received-word output.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt        <= '0;
            bit_cnt        <= '0;
            tx_sr          <= '0;
            rx_sr          <= '0;
            sck_r          <= 1'b0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            div_cnt        <= (state == IDLE || phase_end) ? '0 : div_cnt + CW'(1);
            data_out_valid <= hold_exit;
            if (accept) begin
                tx_sr   <= data_in;
                bit_cnt <= '0;
            end
            if (rise) begin
                sck_r   <= 1'b1;
                rx_sr   <= {rx_sr[DATA_WIDTH-2:0], miso};
                bit_cnt <= bit_cnt + BW'(1);
            end
            // The last fall also shifts, so mosi returns to 0 between frames.
            if (fall) begin
                sck_r <= 1'b0;
                tx_sr <= tx_sr << 1;
            end
            if (hold_exit) data_out <= rx_sr;
            if (chain) begin
                tx_sr   <= chain_word;
                bit_cnt <= '0;
            end
        end
    end

    assign sck  = sck_r;
    assign mosi = tx_sr[DATA_WIDTH-1];

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a mode-0 slave model per DUT instance drives
// miso on sck falling edges and captures mosi on rising edges.
// u0 uses CLK_DIV=2, u1 uses CLK_DIV=5; both DATA_WIDTH=8.
module tb_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic       sck0, cs0, mosi0, v0, dov0, busy0;
    logic       miso0 = 1'b0;
    logic [7:0] din0, dout0;
    logic       sck1, cs1, mosi1, v1, dov1, busy1;
    logic       miso1 = 1'b0;
    logic [7:0] din1, dout1;

    spi_master #(.DATA_WIDTH(8), .CLK_DIV(2)) u0 (
        .clk(clk), .rst(rst), .sck(sck0), .cs(cs0), .mosi(mosi0), .miso(miso0),
        .data_in(din0), .data_in_valid(v0), .data_out(dout0),
        .data_out_valid(dov0), .busy(busy0)
    );
    spi_master #(.DATA_WIDTH(8), .CLK_DIV(5)) u1 (
        .clk(clk), .rst(rst), .sck(sck1), .cs(cs1), .mosi(mosi1), .miso(miso1),
        .data_in(din1), .data_in_valid(v1), .data_out(dout1),
        .data_out_valid(dov1), .busy(busy1)
    );

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- slave model + monitor for u0 ----------------
    logic [7:0] s0_tx, s0_rx;
    int         s0_cnt = 0;
    logic [7:0] rep0_q[$];
    logic [7:0] rx0_q[$];
    logic [7:0] douts0[$];
    int cs_lo0 = 0, rises0 = 0, dov_cnt0 = 0, frames0 = 0, hi_run0 = 0, gap0 = 0;

    always @(negedge cs0) begin
        s0_tx = (rep0_q.size() > 0) ? rep0_q.pop_front() : 8'h00;
        s0_cnt = 0;
        miso0 = s0_tx[7];
        frames0++;
    end
    always @(posedge sck0) begin
        s0_rx = {s0_rx[6:0], mosi0};
        s0_cnt++;
        rises0++;
        if (s0_cnt == 8) rx0_q.push_back(s0_rx);
    end
    always @(negedge sck0) begin
        if (s0_cnt >= 8) begin
            s0_cnt = 0;
            s0_tx = (rep0_q.size() > 0) ? rep0_q.pop_front() : 8'h00;
        end else begin
            s0_tx = s0_tx << 1;
        end
        miso0 = s0_tx[7];
    end
    always @(negedge clk) begin
        if (!cs0) cs_lo0++;
        if (dov0) begin
            dov_cnt0++;
            douts0.push_back(dout0);
        end
        if (cs0 === 1'b1) hi_run0++;
        else begin
            if (hi_run0 > 0) gap0 = hi_run0;
            hi_run0 = 0;
        end
    end

    // ---------------- slave model + monitor for u1 ----------------
    logic [7:0] s1_tx, s1_rx;
    int         s1_cnt = 0;
    logic [7:0] rep1_q[$];
    logic [7:0] rx1_q[$];
    logic [7:0] douts1[$];
    int cs_lo1 = 0, rises1 = 0, dov_cnt1 = 0, run1 = 0;
    int hi_min = 999, hi_max = 0, lo_min = 999, lo_max = 0;
    logic prev1 = 1'b0, seen_hi1 = 1'b0;

    always @(negedge cs1) begin
        s1_tx = (rep1_q.size() > 0) ? rep1_q.pop_front() : 8'h00;
        s1_cnt = 0;
        miso1 = s1_tx[7];
    end
    always @(posedge sck1) begin
        s1_rx = {s1_rx[6:0], mosi1};
        s1_cnt++;
        rises1++;
        if (s1_cnt == 8) rx1_q.push_back(s1_rx);
    end
    always @(negedge sck1) begin
        if (s1_cnt >= 8) begin
            s1_cnt = 0;
            s1_tx = (rep1_q.size() > 0) ? rep1_q.pop_front() : 8'h00;
        end else begin
            s1_tx = s1_tx << 1;
        end
        miso1 = s1_tx[7];
    end
    always @(negedge clk) begin
        if (!cs1) cs_lo1++;
        if (dov1) begin
            dov_cnt1++;
            douts1.push_back(dout1);
        end
        if (sck1 === prev1) run1++;
        else begin
            if (prev1) begin
                if (run1 < hi_min) hi_min = run1;
                if (run1 > hi_max) hi_max = run1;
                seen_hi1 = 1'b1;
            end else if (seen_hi1) begin
                if (run1 < lo_min) lo_min = run1;
                if (run1 > lo_max) lo_max = run1;
            end
            run1 = 1;
            prev1 = sck1;
        end
    end

    // ---------------- helpers ----------------
    task automatic clr0();
        cs_lo0 = 0; rises0 = 0; dov_cnt0 = 0; frames0 = 0;
        rx0_q.delete(); douts0.delete(); rep0_q.delete();
    endtask

    task automatic send0(input logic [7:0] d);
        @(negedge clk);
        din0 = d; v0 = 1'b1;
        @(negedge clk);
        din0 = ~d; v0 = 1'b0;
    endtask

    task automatic wait_idle0(input string name);
        int n = 0;
        while (busy0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk({name, "_timeout"}, 0, 1);
    endtask

    function automatic int qget(input logic [7:0] q[$], input int i);
        return (q.size() > i) ? int'(q[i]) : -1;
    endfunction

    typedef struct {
        logic [7:0] din;
        logic [7:0] rep;
        logic [7:0] exp_dout;
        logic [7:0] exp_rx;
        int         exp_rises;
        int         exp_cslo;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{8'hA5, 8'h3C, 8'h3C, 8'hA5, 8, 36};
        vecs[1] = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8, 36};
        vecs[2] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8, 36};
        vecs[3] = '{8'h81, 8'h7E, 8'h7E, 8'h81, 8, 36};
        vecs[4] = '{8'h5A, 8'hC3, 8'hC3, 8'h5A, 8, 36};

        rst = 1'b1; v0 = 1'b0; din0 = 8'h00; v1 = 1'b0; din1 = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_cs", cs0, 1);
        chk("rst_sck", sck0, 0);
        chk("rst_mosi", mosi0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_dout", dout0, 0);
        chk("rst_dov", dov0, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single frames from the vector table.
        for (int i = 0; i < 5; i++) begin
            clr0();
            rep0_q.push_back(vecs[i].rep);
            send0(vecs[i].din);
            chk($sformatf("v%0d_busy", i), busy0, 1);
            wait_idle0($sformatf("v%0d", i));
            chk($sformatf("v%0d_dov_cnt", i), dov_cnt0, 1);
            chk($sformatf("v%0d_dout", i), qget(douts0, 0), vecs[i].exp_dout);
            chk($sformatf("v%0d_slave_rx", i), qget(rx0_q, 0), vecs[i].exp_rx);
            chk($sformatf("v%0d_sck_rises", i), rises0, vecs[i].exp_rises);
            chk($sformatf("v%0d_cs_low", i), cs_lo0, vecs[i].exp_cslo);
            chk($sformatf("v%0d_mosi_idle", i), mosi0, 0);
        end

`ifndef SPI_MASTER_BURST_EN
        // Valid during SHIFT is ignored.
        clr0();
        rep0_q.push_back(8'h3C);
        send0(8'hA5);
        repeat (10) @(negedge clk);
        send0(8'hFF);
        wait_idle0("ign");
        repeat (20) @(negedge clk);
        chk("ign_frames", frames0, 1);
        chk("ign_rx_cnt", rx0_q.size(), 1);
        chk("ign_rx0", qget(rx0_q, 0), 8'hA5);
        chk("ign_dov_cnt", dov_cnt0, 1);
        chk("ign_busy", busy0, 0);
`else
        // Burst: second word chained into the same cs window, third dropped.
        clr0();
        rep0_q.push_back(8'hAB);
        rep0_q.push_back(8'hCD);
        send0(8'h12);
        repeat (10) @(negedge clk);
        send0(8'h34);
        repeat (4) @(negedge clk);
        send0(8'h56);
        wait_idle0("burst");
        repeat (20) @(negedge clk);
        chk("burst_frames", frames0, 1);
        chk("burst_rises", rises0, 16);
        chk("burst_dov_cnt", dov_cnt0, 2);
        chk("burst_cs_low", cs_lo0, 70);
        chk("burst_rx0", qget(rx0_q, 0), 8'h12);
        chk("burst_rx1", qget(rx0_q, 1), 8'h34);
        chk("burst_rx_cnt", rx0_q.size(), 2);
        chk("burst_dout0", qget(douts0, 0), 8'hAB);
        chk("burst_dout1", qget(douts0, 1), 8'hCD);
`endif

        // Back-to-back: second valid the cycle after busy falls.
        clr0();
        rep0_q.push_back(8'h00);
        send0(8'h00);
        wait_idle0("b2b_a");
        rep0_q.push_back(8'hFF);
        send0(8'hFF);
        wait_idle0("b2b_b");
        chk("b2b_frames", frames0, 2);
        chk("b2b_gap", gap0, 4);
        chk("b2b_dout0", qget(douts0, 0), 8'h00);
        chk("b2b_dout1", qget(douts0, 1), 8'hFF);
        chk("b2b_rx1", qget(rx0_q, 1), 8'hFF);
        chk("b2b_dov_cnt", dov_cnt0, 2);

        // Reset mid-frame aborts with no data_out_valid.
        clr0();
        rep0_q.push_back(8'h3C);
        send0(8'h5A);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_cs", cs0, 1);
        chk("mrst_sck", sck0, 0);
        chk("mrst_busy", busy0, 0);
        chk("mrst_dout", dout0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("mrst_dov_cnt", dov_cnt0, 0);
        chk("mrst_busy_after", busy0, 0);
        chk("mrst_cs_after", cs0, 1);

        // Divider: CLK_DIV=5 instance.
        begin
            int n = 0;
            rep1_q.push_back(8'h5A);
            @(negedge clk);
            din1 = 8'h81; v1 = 1'b1;
            @(negedge clk);
            din1 = 8'h00; v1 = 1'b0;
            while (busy1 && n < 600) begin
                @(negedge clk);
                n++;
            end
            if (n >= 600) chk("div_timeout", 0, 1);
        end
        chk("div_hi_min", hi_min, 5);
        chk("div_hi_max", hi_max, 5);
        chk("div_lo_min", lo_min, 5);
        chk("div_lo_max", lo_max, 5);
        chk("div_rises", rises1, 8);
        chk("div_cs_low", cs_lo1, 90);
        chk("div_dov_cnt", dov_cnt1, 1);
        chk("div_dout", qget(douts1, 0), 8'h5A);
        chk("div_slave_rx", qget(rx1_q, 0), 8'h81);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
